// File: rtl/bcd_seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the BCD seven-segment scanner:
//   - digit_state_t : which digit slot the scanner is currently driving
//   - SEG_0..SEG_9, SEG_DASH, SEG_BLANK : active-high patterns {g,f,e,d,c,b,a}
//   - seg_pattern() : nibble -> active-high pattern (dash for 10..15)
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_TENS = 2'd1,
        S_HUND = 2'd2
    } digit_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-BCD nibbles (10..15) show a single middle bar so bad input is visible.
    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_seg_scan_decode.sv
// -----------------------------------------------------------------------------
// bcd7seg_decode
// Combinational nibble-to-seven-segment decoder, active-high output.
// Ports:
//   nibble  in  4  digit value (0..9 normal, 10..15 shown as a dash)
//   blank   in  1  force all segments off (leading-zero blanking)
//   seg7    out 7  {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module bcd7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg7
);

    // Blanking overrides the digit value.
    always_comb begin
        seg7 = SEG_BLANK;
        if (blank) begin
            seg7 = SEG_BLANK;
        end else begin
            seg7 = seg_pattern(nibble);
        end
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
// Accepts packed BCD words {hund[1:0], tens[3:0], ones[3:0]} over valid/ready
// and scans them onto a 3-digit multiplexed seven-segment display with
// leading-zero blanking. A new word is held in a one-entry pending buffer and
// only copied to the display register at the end of a frame (after the
// hundreds slot), so a frame never mixes digits from two different words.
// Parameters:
//   CLK_DIV         clk cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1: seg/an active-low, 0: active-high
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   bcd_in     in   10  {hund[9:8], tens[7:4], ones[3:0]}
//   bcd_valid  in   1   bcd_in valid this cycle
//   bcd_ready  out  1   a word can be accepted this cycle
//   seg        out  7   segments {g,f,e,d,c,b,a}, registered
//   an         out  3   digit enables {hund, tens, ones}, registered
// -----------------------------------------------------------------------------
module bcd_seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] bcd_in,
    input  logic       bcd_valid,
    output logic       bcd_ready,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]      AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [CNT_W-1:0] cnt_r;
    logic             tick_s;
    digit_state_t     state_r;
    digit_state_t     state_nxt_s;
    logic             frame_end_s;

    logic [9:0]       pend_r;
    logic             pend_full_r;
    logic [9:0]       disp_r;
    logic             accept_s;
    logic             commit_s;

    logic [3:0]       nibble_s;
    logic             blank_s;
    logic [2:0]       an_sel_s;
    logic [6:0]       seg7_s;
    logic [6:0]       seg_r;
    logic [2:0]       an_r;

    assign tick_s      = (cnt_r == CNT_MAX);
    assign frame_end_s = tick_s && (state_r == S_HUND);
    assign bcd_ready   = ~pend_full_r;
    assign accept_s    = bcd_valid && ~pend_full_r;
    // Commit needs pend_full=1 and accept needs pend_full=0, so they are exclusive.
    assign commit_s    = frame_end_s && pend_full_r;

    // Slot divider: free-running 0..CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Next digit slot: rotate ones -> tens -> hund on each tick.
    always_comb begin
        state_nxt_s = state_r;
        if (tick_s) begin
            case (state_r)
                S_ONES:  state_nxt_s = S_TENS;
                S_TENS:  state_nxt_s = S_HUND;
                S_HUND:  state_nxt_s = S_ONES;
                default: state_nxt_s = S_ONES;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Digit-slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_ONES;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pending buffer: filled on handshake, drained into the display at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 10'd0;
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pend_r      <= bcd_in;
            pend_full_r <= 1'b1;
        end else if (commit_s) begin
            pend_full_r <= 1'b0;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Display register: only changes on a frame boundary to avoid tearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_r <= 10'd0;
        end else if (commit_s) begin
            disp_r <= pend_r;
        end else begin
            disp_r <= disp_r;
        end
    end

    // Select the digit for the current slot and apply leading-zero blanking.
    always_comb begin
        nibble_s = 4'd0;
        blank_s  = 1'b0;
        an_sel_s = 3'b000;
        case (state_r)
            S_ONES: begin
                nibble_s = disp_r[3:0];
                blank_s  = 1'b0;
                an_sel_s = 3'b001;
            end
            S_TENS: begin
                nibble_s = disp_r[7:4];
                blank_s  = (disp_r[9:8] == 2'd0) && (disp_r[7:4] == 4'd0);
                an_sel_s = 3'b010;
            end
            S_HUND: begin
                nibble_s = {2'b00, disp_r[9:8]};
                blank_s  = (disp_r[9:8] == 2'd0);
                an_sel_s = 3'b100;
            end
            default: begin
                nibble_s = 4'd0;
                blank_s  = 1'b1;
                an_sel_s = 3'b000;
            end
        endcase
    end

    bcd7seg_decode u_decode (
        .nibble (nibble_s),
        .blank  (blank_s),
        .seg7   (seg7_s)
    );

    // Output registers with polarity applied; both lag the slot state by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_OFF;
        end else if (SEG_ACTIVE_LOW) begin
            seg_r <= ~seg7_s;
            an_r  <= ~an_sel_s;
        end else begin
            seg_r <= seg7_s;
            an_r  <= an_sel_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan (CLK_DIV=4, active-low outputs) with a
// cycle-level reference model checked on every falling edge.
module tb_bcd_seg_scan;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic [9:0] bcd_in    = 10'd0;
    logic       bcd_valid = 1'b0;
    logic       bcd_ready;
    logic [6:0] seg;
    logic [2:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_seg_scan #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: digit value arithmetic plus slot = (cycle/4) mod 3.
    logic [6:0] tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] dig(input int v, input bit blank);
        logic [6:0] hi;
        if (blank)      hi = 7'h00;
        else if (v > 9) hi = 7'h40;
        else            hi = tab[v];
        return ~hi;
    endfunction

    function automatic logic [9:0] expect_out(input logic [9:0] d, input int n);
        int h, t, o, slot;
        h = int'(d[9:8]); t = int'(d[7:4]); o = int'(d[3:0]);
        slot = (n / 4) % 3;
        case (slot)
            0:       return {3'b110, dig(o, 1'b0)};
            1:       return {3'b101, dig(t, (h == 0) && (t == 0))};
            default: return {3'b011, dig(h, h == 0)};
        endcase
    endfunction

    logic [9:0] m_disp, m_pend;
    bit         m_full;
    int         m_n;
    bit         m_on = 1'b0;
    logic [6:0] m_seg;
    logic [2:0] m_an;
    logic [9:0] acc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_disp <= 10'd0;
            m_full <= 1'b0;
            m_n    <= 0;
            m_seg  <= 7'h7F;
            m_an   <= 3'b111;
            m_on   <= 1'b1;
        end else begin
            {m_an, m_seg} <= expect_out(m_disp, m_n);
            if (bcd_valid && !m_full) begin
                m_pend <= bcd_in;
                m_full <= 1'b1;
                acc_q.push_back(bcd_in);
            end else if ((m_n % 4 == 3) && ((m_n / 4) % 3 == 2) && m_full) begin
                m_disp <= m_pend;
                m_full <= 1'b0;
            end
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_seg", {9'd0, seg}, {9'd0, m_seg});
            check("model_an", {13'd0, an}, {13'd0, m_an});
            check("model_ready", {15'd0, bcd_ready}, {15'd0, !m_full});
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_an(input logic [2:0] target, input string nm);
        for (int i = 0; i < 40 && an !== target; i++) @(negedge clk);
        check({nm, "_slot"}, {13'd0, an}, {13'd0, target});
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 40 && bcd_ready !== 1'b1; i++) @(negedge clk);
        check({nm, "_ready"}, {15'd0, bcd_ready}, 16'd1);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [9:0] w, input bit keep, input string nm);
        bcd_in    = w;
        bcd_valid = 1'b1;
        for (int i = 0; i < 60 && bcd_ready !== 1'b1; i++) @(negedge clk);
        check({nm, "_accept"}, {15'd0, bcd_ready}, 16'd1);
        @(negedge clk);
        if (!keep) bcd_valid = 1'b0;
    endtask

    initial begin
        int base;
        #1 rst_n = 1'b0;
        release_reset();
        // 1: reset mid-frame
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_an", {13'd0, an}, 16'h0007);
        check("t1_rst_seg", {9'd0, seg}, 16'h007F);
        release_reset();
        check("t1_ones_an", {13'd0, an}, 16'h0006);
        check("t1_ones_seg", {9'd0, seg}, 16'h0040);
        wait_an(3'b101, "t1_tens"); check("t1_tens_seg", {9'd0, seg}, 16'h007F);
        wait_an(3'b011, "t1_hund"); check("t1_hund_seg", {9'd0, seg}, 16'h007F);
        // 2: 255
        send(10'h255, 1'b0, "t2");
        check("t2_ready_low", {15'd0, bcd_ready}, 16'd0);
        wait_ready("t2");
        wait_an(3'b110, "t2_ones"); check("t2_ones_seg", {9'd0, seg}, 16'h0012);
        wait_an(3'b101, "t2_tens"); check("t2_tens_seg", {9'd0, seg}, 16'h0012);
        wait_an(3'b011, "t2_hund"); check("t2_hund_seg", {9'd0, seg}, 16'h0024);
        // 3: 007
        send(10'h007, 1'b0, "t3");
        wait_ready("t3");
        wait_an(3'b110, "t3_ones"); check("t3_ones_seg", {9'd0, seg}, 16'h0078);
        wait_an(3'b101, "t3_tens"); check("t3_tens_seg", {9'd0, seg}, 16'h007F);
        wait_an(3'b011, "t3_hund"); check("t3_hund_seg", {9'd0, seg}, 16'h007F);
        // 4: back-to-back with valid held
        base = acc_q.size();
        send(10'h255, 1'b1, "t4a");
        send(10'h007, 1'b0, "t4b");
        check("t4_count", 16'(acc_q.size() - base), 16'd2);
        if (acc_q.size() >= base + 2) begin
            check("t4_first", {6'd0, acc_q[base]}, 16'h0255);
            check("t4_second", {6'd0, acc_q[base + 1]}, 16'h0007);
        end
        wait_an(3'b011, "t4_hund"); check("t4_hund_seg", {9'd0, seg}, 16'h0024);
        wait_ready("t4");
        wait_an(3'b110, "t4_ones"); check("t4_ones_seg", {9'd0, seg}, 16'h0078);
        // 5: dash in tens
        send({2'd0, 4'hA, 4'h5}, 1'b0, "t5");
        wait_ready("t5");
        wait_an(3'b110, "t5_ones"); check("t5_ones_seg", {9'd0, seg}, 16'h0012);
        wait_an(3'b101, "t5_tens"); check("t5_tens_seg", {9'd0, seg}, 16'h003F);
        wait_an(3'b011, "t5_hund"); check("t5_hund_seg", {9'd0, seg}, 16'h007F);
        // 6: reset discards a pending word
        send(10'h255, 1'b0, "t6");
        check("t6_ready_low", {15'd0, bcd_ready}, 16'd0);
        #2 rst_n = 1'b0;
        release_reset();
        check("t6_ready", {15'd0, bcd_ready}, 16'd1);
        check("t6_ones_seg", {9'd0, seg}, 16'h0040);
        wait_an(3'b101, "t6_tens"); check("t6_tens_seg", {9'd0, seg}, 16'h007F);
        wait_an(3'b011, "t6_hund"); check("t6_hund_seg", {9'd0, seg}, 16'h007F);
        wait_an(3'b110, "t6_ones2"); check("t6_ones2_seg", {9'd0, seg}, 16'h0040);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
